uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU store path, beside the combined instruction/data memory.
- Snoops the same write bus the memory sees (wen/waddr/wdata) and captures bytes written to the TX data word into a 4-entry FIFO.
- Serialises each byte as 8N1 on a single `tx` pin.
- Returns a status word for reads of the CSR address; the CPU load mux ORs this into its read data.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (minimum 2).
- TX_ADDR, 16'h03F8, byte address of the TX data word (memory word 254).
- CSR_ADDR, 16'h03FC, byte address of the status/control word (memory word 255).
- FIFO_DEPTH, 4, number of TX FIFO entries (fixed power of two).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wen  input  1  store strobe; same signal that drives the memory write enable.
- waddr  input  16  store byte address; decode uses waddr[15:2] only.
- wdata  input  32  store data.
- ren  input  1  load strobe.
- raddr  input  16  load byte address; decode uses raddr[15:2] only.
- csr_rdata  output  32  status word; combinational.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high when the FIFO is non-empty or a frame is in flight.

Behaviour:
- Reset (synchronous, active-high): on the first rising edge with reset=1, clear all state.
  - Values after that edge: tx=1, busy=0, FIFO empty (count=0, pointers 0), overflow=0, FSM=IDLE, baud counter 0.
  - A reset mid-frame aborts the frame; tx returns to 1 after that edge and the partial byte is discarded.
- Address decode: compare word addresses only.
  - TX hit = wen && waddr[15:2]==TX_ADDR[15:2].
  - CSR hit = wen && waddr[15:2]==CSR_ADDR[15:2].
- Push: on a TX hit, wdata[7:0] is written into the FIFO; wdata[31:8] is ignored.
  - The push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle; in that case count is unchanged.
  - Otherwise the byte is dropped and overflow is set to 1 (sticky).
- Overflow clear: a CSR hit with wdata[2]=1 clears overflow.
  - If a dropped push and a clear occur in the same cycle, the set wins.
- csr_rdata:
  - When ren && raddr[15:2]==CSR_ADDR[15:2]: {25'b0, count[2:0], 1'b0, overflow, full, busy}.
    - Bit 0 = busy, bit 1 = full (count==4), bit 2 = overflow, bits 6:4 = count (0..4).
  - Otherwise csr_rdata=0.
  - Reads have no side effects.
- FSM states and actions:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. Shift right after each bit; after bit index 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Baud counter:
  - Counts down from CLKS_PER_BIT-1.
  - A state or bit advance happens in the cycle it reads 0; it reloads on every advance.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: for a TX hit at edge N into an empty, idle block:
  - count=1 after edge N.
  - Pop and START after edge N+1; tx falls after edge N+1.
- busy = (count!=0) || (state!=IDLE). It stays high through the STOP bit of the last frame.
- FIFO pointers are 2-bit and wrap modulo 4; count is 3-bit, range 0..4.
- No reads or writes to any other address affect this block. The memory itself still stores writes to TX_ADDR/CSR_ADDR; that is harmless.

Test Plan (CLKS_PER_BIT=4):
1. Reset sequence:
   - Stimulus: assert reset 2 cycles, then read CSR.
   - Required: tx=1, busy=0, csr_rdata=32'h0.
2. Single byte:
   - Stimulus: write 32'hDEADBE55 to 16'h03F8.
   - Required: tx goes 1 for 0 cycles idle, then start 0 (4 cycles), bits 1,0,1,0,1,0,1,0 (4 cycles each), stop 1 (4 cycles).
   - Required: busy falls exactly 40 cycles after tx falls; total frame 40 cycles.
3. Back-to-back:
   - Stimulus: write 8'h01 and 8'h80 on consecutive cycles.
   - Required: the second start bit begins on the cycle immediately after the first stop bit ends (80 contiguous cycles).
   - Required: CSR count reads 1 during the first frame.
4. Overflow:
   - Stimulus: 6 writes on consecutive cycles to 16'h03F8 with data 0x10..0x15.
   - Required: bytes 0x10..0x14 are transmitted (first popped after write 2, so 5 fit); 0x15 is dropped.
   - Required: CSR shows bit 2=1 and full=1 right after the 6th write.
   - Then write 32'h4 to 16'h03FC; required: overflow reads 0.
5. Full with simultaneous pop:
   - Stimulus: with FIFO full, issue a push on the exact cycle STOP pops the next byte.
   - Required: byte accepted, count stays 4, overflow stays 0.
6. Reset mid-frame and address aliasing:
   - Stimulus: assert reset during DATA bit 3.
   - Required: tx=1 after that edge, count=0, and no further frame is sent.
   - Stimulus: write to 16'h03F9 (aliases word 254).
   - Required: push occurs.
   - Stimulus: write to 16'h03F4.
   - Required: no push occurs.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter that listens on the CPU store bus and keeps a 4-entry TX FIFO.
// A status word is returned combinationally when the CPU loads from the CSR address.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [15:0] TX_ADDR      = 16'h03F8,
  parameter logic [15:0] CSR_ADDR     = 16'h03FC,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wen,
  input  logic [15:0] waddr,
  input  logic [31:0] wdata,
  input  logic        ren,
  input  logic [15:0] raddr,
  output logic [31:0] csr_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int          BAUD_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  FULL_CNT = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q;

  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       overflow_q, overflow_d;

  logic tx_hit, csr_wr_hit, csr_rd_hit;
  logic baud_zero, pop, push, full;
  logic [7:0] head;

  // Only the low byte and the overflow-clear bit of a store carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{waddr[1:0], raddr[1:0], wdata[31:8]};

  always_comb begin
    tx_hit     = wen && (waddr[15:2] == TX_ADDR[15:2]);
    csr_wr_hit = wen && (waddr[15:2] == CSR_ADDR[15:2]);
    csr_rd_hit = ren && (raddr[15:2] == CSR_ADDR[15:2]);
    baud_zero  = (baud_q == '0);
    full       = (count_q == FULL_CNT);
    head       = fifo_mem[rd_ptr_q];
    // A pop frees a slot in the same cycle, so a push into a full FIFO survives it.
    pop        = (count_q != 3'd0) && ((state_q == IDLE) || ((state_q == STOP) && baud_zero));
    push       = tx_hit && (!full || pop);
    busy       = (count_q != 3'd0) || (state_q != IDLE);
    tx         = tx_q;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 3'd1;
    if (pop && !push) count_d = count_q - 3'd1;
    overflow_d = overflow_q;
    if (tx_hit && !push)                overflow_d = 1'b1;
    else if (csr_wr_hit && wdata[2])    overflow_d = 1'b0;
  end

  always_comb begin
    csr_rdata = '0;
    if (csr_rd_hit) csr_rdata = {25'b0, count_q, 1'b0, overflow_q, full, busy};
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            baud_q  <= BAUD_LOAD;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_zero) begin
            baud_q    <= BAUD_LOAD;
            bit_idx_q <= 3'd0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        DATA: begin
          if (baud_zero) begin
            baud_q  <= BAUD_LOAD;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        STOP: begin
          if (baud_zero) begin
            baud_q <= BAUD_LOAD;
            // Back-to-back frames: the next start bit follows the stop bit directly.
            if (pop) begin
              shift_q <= head;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Checks uart_tx_mmio cycle by cycle against a frame-timing reference model,
// using directed scenarios followed by randomized bus traffic.
module tb_uart_tx_mmio;

  localparam int          CPB  = 4;
  localparam int          FLEN = 10 * CPB;
  localparam logic [15:0] TXA  = 16'h03F8;
  localparam logic [15:0] CSRA = 16'h03FC;

  logic        clk = 1'b0;
  logic        reset, wen, ren;
  logic [15:0] waddr, raddr;
  logic [31:0] wdata, csr_rdata;
  logic        tx, busy;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .TX_ADDR(TXA), .CSR_ADDR(CSRA), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .csr_rdata(csr_rdata), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes plus the byte in flight and its elapsed frame time.
  logic [7:0] m_q[$];
  bit         m_in_frame;
  int         m_ft;
  logic [7:0] m_fb;
  bit         m_ovf;

  logic [31:0] csr_seen;
  logic        tx_seen, busy_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!m_in_frame) return 1'b1;
    idx = m_ft / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_fb[idx-1];
  endfunction

  function automatic logic exp_busy();
    return (m_q.size() != 0) || m_in_frame;
  endfunction

  function automatic logic [31:0] exp_csr(input logic r, input logic [15:0] ra);
    logic [2:0] c;
    c = 3'(m_q.size());
    if (!(r && ra[15:2] == CSRA[15:2])) return 32'h0;
    return {25'b0, c, 1'b0, m_ovf, m_q.size() == 4, exp_busy()};
  endfunction

  task automatic model_edge(input logic rst, input logic w, input logic [15:0] wa,
                            input logic [31:0] wd);
    bit tx_h, csr_h, pop, acc;
    if (rst) begin
      m_q.delete();
      m_in_frame = 0; m_ft = 0; m_ovf = 0;
      return;
    end
    tx_h  = w && (wa[15:2] == TXA[15:2]);
    csr_h = w && (wa[15:2] == CSRA[15:2]);
    pop   = (m_q.size() > 0) && (!m_in_frame || m_ft == FLEN - 1);
    acc   = tx_h && (m_q.size() < 4 || pop);
    if (m_in_frame) begin
      m_ft++;
      if (m_ft == FLEN) m_in_frame = 0;
    end
    if (pop) begin
      m_fb = m_q.pop_front();
      m_in_frame = 1;
      m_ft = 0;
    end
    if (acc) m_q.push_back(wd[7:0]);
    if (tx_h && !acc) m_ovf = 1;
    else if (csr_h && wd[2]) m_ovf = 0;
  endtask

  // One bus cycle: drive at the falling edge, check csr before the rising edge,
  // then check tx/busy at the next falling edge.
  task automatic step(input logic rst, input logic w, input logic [15:0] wa,
                      input logic [31:0] wd, input logic r, input logic [15:0] ra);
    reset = rst; wen = w; waddr = wa; wdata = wd; ren = r; raddr = ra;
    #1;
    csr_seen = csr_rdata;
    check("csr_rdata", csr_seen, exp_csr(r, ra));
    @(posedge clk);
    model_edge(rst, w, wa, wd);
    @(negedge clk);
    tx_seen = tx;
    busy_seen = busy;
    check("tx", {31'b0, tx_seen}, {31'b0, exp_tx()});
    check("busy", {31'b0, busy_seen}, {31'b0, exp_busy()});
    wen = 0; ren = 0; reset = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 32'h0, 0, 16'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    step(0, 1, a, d, 0, 16'h0);
  endtask

  task automatic rd_csr();
    step(0, 0, 16'h0, 32'h0, 1, CSRA);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_busy() && n < 400) begin idle(1); n++; end
    check("drain_bound", {31'b0, exp_busy()}, 32'h0);
  endtask

  task automatic wait_ft(input int target);
    int n = 0;
    while (!(m_in_frame && m_ft == target) && n < 200) begin idle(1); n++; end
    check("wait_ft_bound", (m_in_frame && m_ft == target) ? 32'h1 : 32'h0, 32'h1);
  endtask

  initial begin
    int n;
    reset = 1; wen = 0; ren = 0; waddr = 0; raddr = 0; wdata = 0;
    m_in_frame = 0; m_ft = 0; m_ovf = 0; m_fb = 0;
    @(negedge clk);

    // Reset sequence
    step(1, 0, 16'h0, 32'h0, 0, 16'h0);
    step(1, 0, 16'h0, 32'h0, 0, 16'h0);
    rd_csr();
    check("reset_csr", csr_seen, 32'h0);
    check("reset_tx", {31'b0, tx_seen}, 32'h1);
    check("reset_busy", {31'b0, busy_seen}, 32'h0);

    // Single byte: tx falls one edge after the push, busy 40 cycles later
    wr(TXA, 32'hDEADBE55);
    idle(1);
    check("single_start", {31'b0, tx_seen}, 32'h0);
    n = 0;
    while (busy_seen && n < 100) begin idle(1); n++; end
    check("single_frame_len", n, FLEN);

    // Back-to-back frames with count 1 during the first frame
    idle(3);
    wr(TXA, 32'h01);
    wr(TXA, 32'h80);
    idle(5);
    rd_csr();
    check("b2b_count1", csr_seen, 32'h11);
    drain();

    // Overflow: six consecutive pushes, five fit
    for (int i = 0; i < 6; i++) wr(TXA, 32'h10 + i);
    rd_csr();
    check("ovf_set", csr_seen, 32'h47);
    wr(CSRA, 32'h4);
    rd_csr();
    check("ovf_clear", csr_seen, 32'h43);
    drain();

    // Full FIFO with a push on the exact pop cycle
    for (int i = 0; i < 5; i++) wr(TXA, 32'hA0 + i);
    wait_ft(FLEN - 1);
    step(0, 1, TXA, 32'hB5, 1, CSRA);
    rd_csr();
    check("full_pop_push", csr_seen, 32'h43);
    drain();

    // Reset during data bit 3, then address aliasing
    wr(TXA, 32'h5A);
    wait_ft(4 * CPB + 1);
    step(1, 0, 16'h0, 32'h0, 0, 16'h0);
    check("midframe_tx", {31'b0, tx_seen}, 32'h1);
    rd_csr();
    check("midframe_csr", csr_seen, 32'h0);
    idle(50);
    wr(16'h03F9, 32'h3C);
    rd_csr();
    check("alias_push", csr_seen, 32'h11);
    drain();
    wr(16'h03F4, 32'h77);
    rd_csr();
    check("nohit_push", csr_seen, 32'h0);

    // Randomized bus traffic
    for (int i = 0; i < 3000; i++) begin
      logic        w, r, rst;
      logic [15:0] wa, ra;
      logic [31:0] wd;
      int          sel, rate;
      rate = (i / 500) % 2 == 0 ? 4 : 40;
      w    = ($urandom_range(rate - 1) == 0);
      sel  = $urandom_range(9);
      case (sel)
        0, 1, 2, 3: wa = TXA;
        4:          wa = TXA | 16'($urandom_range(3));
        5, 6:       wa = CSRA | 16'($urandom_range(3));
        7:          wa = 16'h03F4;
        default:    wa = 16'($urandom);
      endcase
      wd  = $urandom;
      r   = $urandom_range(1) == 1;
      ra  = ($urandom_range(2) != 0) ? (CSRA | 16'($urandom_range(3))) : 16'($urandom);
      rst = ($urandom_range(799) == 0);
      step(rst, w, wa, wd, r, ra);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
